// File: rtl/mult_sched_pkg.sv
// Shared types and the round-robin grant rule for the two-requester multiply scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} sched_state_t;

    localparam int ID_W = 1;

    // When both requesters are valid, the one not served last wins.
    function automatic logic [ID_W-1:0] rr_grant(input logic v0, input logic v1,
                                                 input logic [ID_W-1:0] last_id);
        if (v0 && v1) return ~last_id;
        else if (v1)  return 1'b1;
        else          return 1'b0;
    endfunction

endpackage

// File: rtl/mult_shift_dp.sv
// Shift-and-double multiply datapath: load seeds the registers, each step consumes one multiplier bit.
module mult_shift_dp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last_step
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    assign last_step = (count == LAST_CNT);

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one shift-and-double multiplier between two requesters.
module mult_rr_sched
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               rsp_id,
    output logic               busy
);

    sched_state_t      state, state_next;
    logic [ID_W-1:0]   grant, id, last_id;
    logic              load, step, last_step;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]  op_a, op_b;

    assign grant = rr_grant(req0_valid, req1_valid, last_id);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated by rst_n so no ready leaks out while reset holds the FSM in IDLE.
                req0_ready = rst_n && req0_valid && (grant == 1'b0);
                req1_ready = rst_n && req1_valid && (grant == 1'b1);
                if (req0_ready || req1_ready) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            id      <= '0;
            last_id <= 1'b1;
        end else begin
            state <= state_next;
            if (load) id <= req1_ready ? 1'b1 : 1'b0;
            if (state == DONE && rsp_ready) last_id <= id;
        end
    end

    assign op_a = req1_ready ? req1_a : req0_a;
    assign op_b = req1_ready ? req1_b : req0_b;

    mult_shift_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .a         (op_a),
        .b         (op_b),
        .acc       (acc),
        .last_step (last_step)
    );

    assign rsp_product = (state == DONE) ? acc : '0;
    assign rsp_id      = (state == DONE) ? id : 1'b0;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mult_rr_sched.sv
// Self-checking bench for mult_rr_sched: vector table, hand corner sequences, randomized arbitration.
module tb_mult_rr_sched;

    localparam int W = 8;

    logic           clk, rst_n;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id, busy;
    logic [2*W-1:0] rsp_product;

    int checks = 0;
    int errors = 0;
    logic model_last;

    mult_rr_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
        .rsp_id(rsp_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Issue one operation from requester 'who' (called at a negedge) and check its response.
    task automatic serve(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_prod, input bit keep, input string tag);
        int n;
        bit bad;
        if (who == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else          begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        chk({tag, " ready_granted"}, 32'(who == 0 ? req0_ready : req1_ready), 32'd1);
        chk({tag, " ready_other"},   32'(who == 0 ? req1_ready : req0_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin
            if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
        n = 1;
        bad = 1'b0;
        while (!rsp_valid && n <= 40) begin
            if (!busy || req0_ready || req1_ready) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(W + 1));
        chk({tag, " busy_noaccept"}, 32'(bad), 32'd0);
        chk({tag, " product"}, 32'(rsp_product), 32'(exp_prod));
        chk({tag, " id"}, 32'(rsp_id), 32'(who));
        @(negedge clk);
        chk({tag, " rsp_cleared"}, 32'(rsp_valid), 32'd0);
        model_last = (who != 0);
    endtask

    typedef struct {
        int             who;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        bit seen;
        logic [W-1:0] a0, b0, a1, b1;
        int pat, first;

        tbl[0] = '{0, 8'd3,   8'd5,   16'd15};
        tbl[1] = '{1, 8'd255, 8'd255, 16'd65025};
        tbl[2] = '{0, 8'd0,   8'd200, 16'd0};
        tbl[3] = '{1, 8'd1,   8'd1,   16'd1};
        tbl[4] = '{0, 8'd128, 8'd2,   16'd256};
        tbl[5] = '{1, 8'd200, 8'd0,   16'd0};

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        model_last = 1'b1;
        #12;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset product", 32'(rsp_product), 32'd0);
        chk("reset id", 32'(rsp_id), 32'd0);
        chk("reset readies", 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            serve(tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].prod, 1'b0, $sformatf("vec%0d", i));

        // Backpressure in DONE while req1 waits.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9;
        #1;
        chk("bp ready0", 32'(req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        chk("bp reached_done", 32'(rsp_valid), 32'd1);
        req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd11;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp hold%0d product", i), 32'(rsp_product), 32'd63);
            chk($sformatf("bp hold%0d id", i), 32'(rsp_id), 32'd0);
            chk($sformatf("bp hold%0d valid_readies", i),
                32'({rsp_valid, req0_ready, req1_ready}), 32'b100);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        model_last = 1'b0;
        serve(1, 8'd10, 8'd11, 16'd110, 1'b0, "bp_next");

        // Fresh reset, then continuous contention must strictly alternate starting with req0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'd4; req1_b = 8'd5;
        serve(0, 8'd2, 8'd3, 16'd6,  1'b1, "rr0");
        serve(1, 8'd4, 8'd5, 16'd20, 1'b1, "rr1");
        serve(0, 8'd2, 8'd3, 16'd6,  1'b1, "rr2");
        serve(1, 8'd4, 8'd5, 16'd20, 1'b0, "rr3");
        req0_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of RUN drops the operation.
        req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst product", 32'(rsp_product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("midrst no_stale", 32'(seen), 32'd0);
        req1_valid = 1'b1; req1_a = 8'd13; req1_b = 8'd3;
        serve(0, 8'd6, 8'd7, 16'd42, 1'b0, "midrst_first");
        serve(1, 8'd13, 8'd3, 16'd39, 1'b0, "midrst_second");

        // Random traffic against the arithmetic and round-robin model.
        for (int it = 0; it < 30; it++) begin
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            pat = int'($urandom_range(0, 2));
            if (pat == 0) serve(0, a0, b0, 16'(a0) * 16'(b0), 1'b0, $sformatf("rnd%0d", it));
            else if (pat == 1) serve(1, a1, b1, 16'(a1) * 16'(b1), 1'b0, $sformatf("rnd%0d", it));
            else begin
                first = model_last ? 0 : 1;
                if (first == 0) begin
                    req1_valid = 1'b1; req1_a = a1; req1_b = b1;
                    serve(0, a0, b0, 16'(a0) * 16'(b0), 1'b0, $sformatf("rnd%0d_a", it));
                    serve(1, a1, b1, 16'(a1) * 16'(b1), 1'b0, $sformatf("rnd%0d_b", it));
                end else begin
                    req0_valid = 1'b1; req0_a = a0; req0_b = b0;
                    serve(1, a1, b1, 16'(a1) * 16'(b1), 1'b0, $sformatf("rnd%0d_a", it));
                    serve(0, a0, b0, 16'(a0) * 16'(b0), 1'b0, $sformatf("rnd%0d_b", it));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
